// File: rtl/stim_pkg.sv
// rtl/stim_pkg.sv - shared state encoding, defaults and Gray helper for stim_sequencer
//
// Contents:
//   state_t        : IDLE / DRIVE / DONE sequencer states
//   DWELL_DEFAULT  : default cycles each vector is held
//   NVEC_DEFAULT   : default vectors per sweep
//   bin2gray()     : 3-bit binary to reflected Gray conversion
package stim_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DWELL_DEFAULT = 10;
    localparam int NVEC_DEFAULT  = 8;

    function automatic logic [2:0] bin2gray(input logic [2:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/dwell_counter.sv
// rtl/dwell_counter.sv - per-vector hold counter with clear, enable and terminal count
//
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   clr      : force count to 0 (takes effect on next edge)
//   en       : advance the count; wraps to 0 after terminal count
//   tc       : high while count == DWELL-1
module dwell_counter
    import stim_pkg::*;
#(
    parameter int DWELL = DWELL_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [7:0] count;

    assign tc = (count == 8'(DWELL - 1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= 8'd0;
        end else if (en) begin
            count <= tc ? 8'd0 : count + 8'd1;
        end
    end

endmodule

// File: rtl/stim_sequencer.sv
// rtl/stim_sequencer.sv - exhaustive 3-input stimulus sweeper for a gate under test
//
// Parameters: DWELL (1..255) cycles per vector, NVEC (2..8) vectors per sweep.
// Macro STIM_GRAY_EN: when defined {a,b,c} is the Gray code of vec_idx,
// otherwise {a,b,c} is vec_idx in binary.
//
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   start, loop   : begin a sweep (IDLE only); loop captured with start
//   stop          : abort back to IDLE without a done pulse
//   a, b, c       : stimulus bits, a = MSB
//   vec_idx       : index of the vector being driven
//   vec_valid     : first cycle of each new vector
//   busy          : high while driving
//   done          : one-cycle pulse after a non-looping sweep
//
// All outputs are registered from the next-state values, so each output
// reflects the state entered on the same edge.
module stim_sequencer
    import stim_pkg::*;
#(
    parameter int DWELL = DWELL_DEFAULT,
    parameter int NVEC  = NVEC_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       loop,
    input  logic       stop,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic [2:0] vec_idx,
    output logic       vec_valid,
    output logic       busy,
    output logic       done
);

    localparam logic [2:0] LAST_IDX = 3'(NVEC - 1);

    state_t     state, state_n;
    logic       loop_q, loop_n;
    logic [2:0] idx_n;
    logic [2:0] abc_n;
    logic       valid_n;
    logic       cnt_clr, cnt_en, cnt_tc;

    dwell_counter #(.DWELL(DWELL)) u_dwell (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .en  (cnt_en),
        .tc  (cnt_tc)
    );

    always_comb begin
        state_n = state;
        loop_n  = loop_q;
        idx_n   = 3'd0;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        case (state)
            IDLE: begin
                cnt_clr = 1'b1;
                // stop has priority over a simultaneous start
                if (start && !stop) begin
                    state_n = DRIVE;
                    loop_n  = loop;
                end
            end
            DRIVE: begin
                if (stop) begin
                    state_n = IDLE;
                    cnt_clr = 1'b1;
                end else begin
                    cnt_en = 1'b1;
                    idx_n  = vec_idx;
                    if (cnt_tc) begin
                        if (vec_idx == LAST_IDX) begin
                            idx_n = 3'd0;
                            if (!loop_q) begin
                                state_n = DONE;
                            end
                        end else begin
                            idx_n = vec_idx + 3'd1;
                        end
                    end
                end
            end
            DONE: begin
                cnt_clr = 1'b1;
                state_n = IDLE;
            end
            default: begin
                cnt_clr = 1'b1;
                state_n = IDLE;
            end
        endcase

        // New vector on DRIVE entry and on every dwell rollover (every
        // cycle when DWELL is 1, since the terminal count is always high).
        valid_n = (state_n == DRIVE) && ((state != DRIVE) || cnt_tc);

        abc_n = 3'd0;
        if (state_n == DRIVE) begin
`ifdef STIM_GRAY_EN
            abc_n = bin2gray(idx_n);
`else
            abc_n = idx_n;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            loop_q    <= 1'b0;
            vec_idx   <= 3'd0;
            {a, b, c} <= 3'b000;
            vec_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            loop_q    <= loop_n;
            vec_idx   <= idx_n;
            {a, b, c} <= abc_n;
            vec_valid <= valid_n;
            busy      <= (state_n == DRIVE);
            done      <= (state_n == DONE);
        end
    end

endmodule

// File: tb/tb_stim_sequencer.sv
// tb/tb_stim_sequencer.sv - self-checking bench for stim_sequencer (DWELL=10 and DWELL=1 instances)
//
// Both instances share inputs. The reference model tracks, per instance, the
// sweep phase and the number of cycles elapsed in the sweep; expected outputs
// are derived arithmetically (index = elapsed / DWELL, new vector when
// elapsed is a multiple of DWELL). Build with STIM_GRAY_EN to check Gray mode.
module tb_stim_sequencer;

    localparam int NV     = 8;
    localparam int P_IDLE = 0;
    localparam int P_DRV  = 1;
    localparam int P_DONE = 2;

    bit   clk = 1'b0;
    logic rst, start, loop, stop;

    logic       a0, b0, c0, vv0, busy0, done0;
    logic [2:0] idx0;
    logic       a1, b1, c1, vv1, busy1, done1;
    logic [2:0] idx1;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    int   ph [2] = '{P_IDLE, P_IDLE};
    int   t  [2] = '{0, 0};
    bit   lp [2] = '{1'b0, 1'b0};
    int   dw [2] = '{10, 1};
    logic [2:0] code_tab [8];
    logic [2:0] prev_abc1;
    int         prev_ph1;

    always #5 clk = ~clk;

    stim_sequencer #(.DWELL(10), .NVEC(NV)) dut0 (
        .clk(clk), .rst(rst), .start(start), .loop(loop), .stop(stop),
        .a(a0), .b(b0), .c(c0), .vec_idx(idx0), .vec_valid(vv0),
        .busy(busy0), .done(done0)
    );

    stim_sequencer #(.DWELL(1), .NVEC(NV)) dut1 (
        .clk(clk), .rst(rst), .start(start), .loop(loop), .stop(stop),
        .a(a1), .b(b1), .c(c1), .vec_idx(idx1), .vec_valid(vv1),
        .busy(busy1), .done(done1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else begin
            failed = failed + 1;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [2:0] abc, idx;
        logic       vv, bsy, dn;
        int         vi;
        for (int k = 0; k < 2; k++) begin
            abc = (k == 0) ? {a0, b0, c0} : {a1, b1, c1};
            idx = (k == 0) ? idx0 : idx1;
            vv  = (k == 0) ? vv0 : vv1;
            bsy = (k == 0) ? busy0 : busy1;
            dn  = (k == 0) ? done0 : done1;
            chk($sformatf("dut%0d busy", k), 32'(bsy), 32'(ph[k] == P_DRV));
            chk($sformatf("dut%0d done", k), 32'(dn), 32'(ph[k] == P_DONE));
            if (ph[k] == P_DRV) begin
                vi = t[k] / dw[k];
                chk($sformatf("dut%0d vec_idx", k), 32'(idx), 32'(vi));
                chk($sformatf("dut%0d abc", k), 32'(abc), 32'(code_tab[vi]));
                chk($sformatf("dut%0d vec_valid", k), 32'(vv), 32'((t[k] % dw[k]) == 0));
            end else begin
                chk($sformatf("dut%0d abc_idle", k), 32'(abc), 32'd0);
                chk($sformatf("dut%0d vec_valid_idle", k), 32'(vv), 32'd0);
                if (ph[k] == P_IDLE) begin
                    chk($sformatf("dut%0d vec_idx_idle", k), 32'(idx), 32'd0);
                end
            end
        end
`ifdef STIM_GRAY_EN
        if (ph[1] == P_DRV && prev_ph1 == P_DRV) begin
            chk("dut1 gray_hamming", 32'($countones({a1, b1, c1} ^ prev_abc1)), 32'd1);
        end
`endif
        prev_abc1 = {a1, b1, c1};
        prev_ph1  = ph[1];
    endtask

    task automatic model_edge(input bit r, input bit s, input bit p, input bit l);
        for (int k = 0; k < 2; k++) begin
            if (r) begin
                ph[k] = P_IDLE;
            end else begin
                case (ph[k])
                    P_IDLE: if (s && !p) begin
                        ph[k] = P_DRV;
                        t[k]  = 0;
                        lp[k] = l;
                    end
                    P_DRV: begin
                        if (p) begin
                            ph[k] = P_IDLE;
                        end else if (t[k] + 1 == dw[k] * NV) begin
                            if (lp[k]) t[k] = 0;
                            else       ph[k] = P_DONE;
                        end else begin
                            t[k] = t[k] + 1;
                        end
                    end
                    default: ph[k] = P_IDLE;
                endcase
            end
        end
    endtask

    task automatic step(input bit r, input bit s, input bit p, input bit l);
        rst = r; start = s; stop = p; loop = l;
        @(posedge clk);
        model_edge(r, s, p, l);
        #1;
        check_all();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
`ifdef STIM_GRAY_EN
        code_tab = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};
`else
        for (int i = 0; i < 8; i++) code_tab[i] = 3'(i);
`endif
        prev_abc1 = 3'd0;
        prev_ph1  = P_IDLE;
        rst = 1'b1; start = 1'b0; stop = 1'b0; loop = 1'b0;

        // reset state, with start asserted to show reset priority
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);

        // start and stop together in IDLE: stays idle
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
        idle_cycles(2);

        // single non-looping sweep: 80 busy cycles then done at cycle 81
        step(1'b0, 1'b1, 1'b0, 1'b0);
        idle_cycles(90);

        // start re-pulsed at cycle 30 of a sweep is ignored
        step(1'b0, 1'b1, 1'b0, 1'b0);
        idle_cycles(29);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        idle_cycles(60);

        // looping sweep, wraps at cycle 80, stopped after 100 cycles
        step(1'b0, 1'b1, 1'b0, 1'b1);
        idle_cycles(99);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        idle_cycles(5);

        // reset at cycle 25 of a sweep
        step(1'b0, 1'b1, 1'b0, 1'b0);
        idle_cycles(24);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        idle_cycles(5);

        // randomized control traffic
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 39) == 0),
                 1'($urandom_range(0, 1)));
        end
        idle_cycles(100);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/stim_sequencer.md
STIM_SEQUENCER -- requirements
Module: stim_sequencer

Interface
REQ-001 Parameter DWELL, default 10, clock cycles each input vector is held (legal 1..255).
REQ-002 Parameter NVEC, default 8, number of vectors per sweep (legal 2..8).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  begin a sweep; sampled only in IDLE.
REQ-006 loop  input  1  sampled with start; 1 = repeat sweeps until stop.
REQ-007 stop  input  1  abort sweep; sampled in DRIVE and DONE.
REQ-008 a, b, c  output  1 each  stimulus to downstream 3-input gate under test; a = MSB, c = LSB.
REQ-009 vec_idx  output  3  index of vector currently driven.
REQ-010 vec_valid  output  1  high on the first cycle of each new vector.
REQ-011 busy  output  1  high in DRIVE.
REQ-012 done  output  1  one-cycle pulse at end of a non-loop sweep.

Function
REQ-013 FSM states SHALL be IDLE, DRIVE, DONE.
REQ-014 IDLE: a,b,c = 000, vec_idx = 0, busy = 0; start = 1 and stop = 0 -> DRIVE next cycle.
REQ-015 Entry to DRIVE SHALL drive vector 0 and assert vec_valid on that same first DRIVE cycle (latency from start = 1 cycle).
REQ-016 Each vector SHALL be held exactly DWELL cycles; dwell counter runs 0..DWELL-1.
REQ-017 At dwell count DWELL-1, vec_idx SHALL increment, {a,b,c} update, vec_valid pulse next cycle.
REQ-018 At last vector (NVEC-1) end of dwell: loop latched 1 -> wrap to vector 0 with vec_valid; loop latched 0 -> DONE.
REQ-019 DONE SHALL last one cycle with done = 1, a,b,c = 000, then IDLE.
REQ-020 stop = 1 in DRIVE SHALL force IDLE next cycle, a,b,c = 000, no done pulse.
REQ-021 start while busy SHALL be ignored; loop SHALL be latched only at start acceptance.
REQ-022 start and stop both high in IDLE: stop wins, remain IDLE.
REQ-023 DWELL = 1: a new vector every cycle; vec_valid held high through the sweep.
REQ-024 Outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-025 rst SHALL set state IDLE, a,b,c = 000, vec_idx = 0, vec_valid = 0, busy = 0, done = 0, dwell counter = 0, loop latch = 0.
REQ-026 rst mid-sweep SHALL take priority over start/stop; no done pulse generated.

Configuration
REQ-027 Macro STIM_GRAY_EN defined: {a,b,c} SHALL equal Gray code of vec_idx (000,001,011,010,110,111,101,100), one input changes per step.
REQ-028 Macro undefined: {a,b,c} SHALL equal binary vec_idx (000..111); vec_idx sequence unchanged in both builds.

Structure
REQ-029 Package stim_pkg SHALL hold state encoding constants (IDLE, DRIVE, DONE), default DWELL/NVEC, and the Gray-conversion function.
REQ-030 Sub-module dwell_counter SHALL implement the per-vector hold counter with clear/enable inputs and terminal-count output.

Verification
REQ-031 rst, start=1 loop=0, DWELL=10, NVEC=8 -> abc 000..111 each held 10 cycles, busy 80 cycles, done pulse at cycle 81, then IDLE.
REQ-032 start with loop=1, stop after 100 cycles -> wrap 111->000 at cycle 80 with vec_valid, IDLE one cycle after stop, abc=000, no done.
REQ-033 start pulsed again at cycle 30 of a sweep -> no effect; sweep timing identical to REQ-031.
REQ-034 rst asserted at cycle 25 of sweep -> next cycle all outputs at reset values, no done.
REQ-035 STIM_GRAY_EN build, DWELL=1 -> abc 000,001,011,010,110,111,101,100 on consecutive cycles, Hamming distance 1 each step.
REQ-036 start and stop high together in IDLE -> busy stays 0, abc stays 000.
